// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller for a 5-stage core: merges load-use, fetch-busy,
// memory-busy and EX branch redirect into per-stage enables/flushes.
module pipeline_stall_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_use_hazard,
  input  logic                  if_busy,
  input  logic                  mem_busy,
  input  logic                  ex_branch_taken,
  input  logic [ADDR_WIDTH-1:0] ex_branch_target,
  output logic                  pc_we,
  output logic                  pc_redirect,
  output logic [ADDR_WIDTH-1:0] pc_redirect_addr,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  memwb_flush,
  output logic                  redirect_pending,
  output logic [CNT_WIDTH-1:0]  stall_cycles
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pend_target_q, pend_target_d;
  logic [CNT_WIDTH-1:0]  stall_cycles_q, stall_cycles_d;

  always_comb begin
    state_d          = state_q;
    pend_target_d    = pend_target_q;
    pc_we            = 1'b1;
    pc_redirect      = 1'b0;
    pc_redirect_addr = (state_q == PEND) ? pend_target_q : ex_branch_target;
    redirect_pending = (state_q == PEND);
    ifid_en          = 1'b1;
    idex_en          = 1'b1;
    exmem_en         = 1'b1;
    memwb_en         = 1'b1;
    ifid_flush       = 1'b0;
    idex_flush       = 1'b0;
    exmem_flush      = 1'b0;
    memwb_flush      = 1'b0;

    if (!rst_n) begin
      pc_we            = 1'b0;
      redirect_pending = 1'b0;
      ifid_en          = 1'b0;
      idex_en          = 1'b0;
      exmem_en         = 1'b0;
      memwb_en         = 1'b0;
      ifid_flush       = 1'b1;
      idex_flush       = 1'b1;
      exmem_flush      = 1'b1;
      memwb_flush      = 1'b1;
    end else if (mem_busy) begin
      // Whole front end frozen; EX re-presents its branch/hazard next cycle.
      pc_we       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (state_q == PEND) begin
      ifid_flush = 1'b1;
      if (if_busy) begin
        pc_we = 1'b0;
        if (load_use_hazard) begin
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end else begin
        pc_redirect = 1'b1;
        state_d     = RUN;
      end
    end else if (ex_branch_taken && !if_busy) begin
      pc_redirect = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (ex_branch_taken) begin
      pc_we         = 1'b0;
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      pend_target_d = ex_branch_target;
      state_d       = PEND;
    end else if (if_busy) begin
      pc_we      = 1'b0;
      ifid_flush = 1'b1;
      if (load_use_hazard) begin
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end else if (load_use_hazard) begin
      pc_we      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end

    stall_cycles_d = stall_cycles_q;
    if (!pc_we && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= RUN;
      pend_target_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      pend_target_q  <= pend_target_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: per-cycle expectations queued at drive
// time and checked mid-cycle; a 4-bit-counter instance covers saturation.
module tb_pipeline_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_use_hazard, if_busy, mem_busy, ex_branch_taken;
  logic [31:0] ex_branch_target;

  logic        pc_we, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, redirect_pending;
  logic [31:0] pc_redirect_addr, stall_cycles;

  logic        s_pc_we, s_pc_redirect, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic        s_ifid_flush, s_idex_flush, s_exmem_flush, s_memwb_flush, s_pending;
  logic [31:0] s_addr;
  logic [3:0]  s_stall;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .load_use_hazard(load_use_hazard), .if_busy(if_busy),
    .mem_busy(mem_busy), .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .pc_we(pc_we), .pc_redirect(pc_redirect), .pc_redirect_addr(pc_redirect_addr),
    .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .redirect_pending(redirect_pending), .stall_cycles(stall_cycles)
  );

  pipeline_stall_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .load_use_hazard(load_use_hazard), .if_busy(if_busy),
    .mem_busy(mem_busy), .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .pc_we(s_pc_we), .pc_redirect(s_pc_redirect), .pc_redirect_addr(s_addr),
    .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en), .memwb_en(s_memwb_en),
    .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush),
    .memwb_flush(s_memwb_flush), .redirect_pending(s_pending), .stall_cycles(s_stall)
  );

  // {pc_we, pc_redirect, ifid/idex/exmem/memwb_en, ifid/idex/exmem/memwb_flush, redirect_pending}
  localparam logic [10:0] C_RST   = 11'b0_0_0000_1111_0;
  localparam logic [10:0] C_NORM  = 11'b1_0_1111_0000_0;
  localparam logic [10:0] C_LU    = 11'b0_0_0111_0100_0;
  localparam logic [10:0] C_BR    = 11'b1_1_1111_1100_0;
  localparam logic [10:0] C_MEMB  = 11'b0_0_0001_0001_0;
  localparam logic [10:0] C_BRIFB = 11'b0_0_1111_1100_0;
  localparam logic [10:0] C_PBUSY = 11'b0_0_1111_1000_1;
  localparam logic [10:0] C_PDONE = 11'b1_1_1111_1000_1;
  localparam logic [10:0] C_IFB   = 11'b0_0_1111_1000_0;
  localparam logic [10:0] C_IFBLU = 11'b0_0_0111_1100_0;

  typedef struct {
    string       tag;
    logic [10:0] ctrl;
    logic [31:0] addr;
    logic [31:0] stall;
    logic [3:0]  sat;
    bit          chk_sat;
  } exp_t;

  exp_t sb[$];

  function automatic logic [10:0] ctrl_obs();
    return {pc_we, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_flush, idex_flush, exmem_flush, memwb_flush, redirect_pending};
  endfunction

  // A redirect cannot be requested while one is already pending.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && redirect_pending === 1'b1) begin
      n_total++;
      assert (ex_branch_taken === 1'b0) n_pass++;
      else $error("FAIL branch_in_pend: observed ex_branch_taken=%b expected 0", ex_branch_taken);
    end
  end

  task automatic step(input string tag, input logic rn, input logic lu, input logic ifb,
                      input logic mb, input logic br, input logic [31:0] tgt,
                      input logic [10:0] ectrl, input logic [31:0] eaddr,
                      input logic [31:0] estall, input logic [3:0] esat, input bit csat);
    exp_t e;
    rst_n = rn; load_use_hazard = lu; if_busy = ifb; mem_busy = mb;
    ex_branch_taken = br; ex_branch_target = tgt;
    sb.push_back('{tag, ectrl, eaddr, estall, esat, csat});
    @(negedge clk);
    e = sb.pop_front();
    n_total++;
    assert (ctrl_obs() === e.ctrl) n_pass++;
    else $error("FAIL %s ctrl: observed %b expected %b", e.tag, ctrl_obs(), e.ctrl);
    n_total++;
    assert (pc_redirect_addr === e.addr) n_pass++;
    else $error("FAIL %s addr: observed %h expected %h", e.tag, pc_redirect_addr, e.addr);
    n_total++;
    assert (stall_cycles === e.stall) n_pass++;
    else $error("FAIL %s stall: observed %0d expected %0d", e.tag, stall_cycles, e.stall);
    if (e.chk_sat) begin
      n_total++;
      assert (s_stall === e.sat) n_pass++;
      else $error("FAIL %s sat_stall: observed %0d expected %0d", e.tag, s_stall, e.sat);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; load_use_hazard = 1'b0; if_busy = 1'b0; mem_busy = 1'b0;
    ex_branch_taken = 1'b0; ex_branch_target = '0;
    @(posedge clk);
    #1;
    //   tag          rn  lu ifb mb br target        ctrl     addr          stall sat chk
    step("reset",     0,  0, 0,  0, 0, 32'h0,        C_RST,   32'h0,        0,    0,  1);
    step("idle",      1,  0, 0,  0, 0, 32'h0,        C_NORM,  32'h0,        0,    0,  1);
    step("loaduse",   1,  1, 0,  0, 0, 32'h0,        C_LU,    32'h0,        0,    0,  0);
    step("lu_after",  1,  0, 0,  0, 0, 32'h0,        C_NORM,  32'h0,        1,    0,  0);
    step("br_lu",     1,  1, 0,  0, 1, 32'h8000_0040, C_BR,   32'h8000_0040, 1,   0,  0);
    step("br_after",  1,  0, 0,  0, 0, 32'h0,        C_NORM,  32'h0,        1,    0,  0);
    step("reset2",    0,  0, 0,  0, 0, 32'h0,        C_RST,   32'h0,        1,    0,  0);
    step("memb1",     1,  1, 0,  1, 1, 32'h8000_0040, C_MEMB, 32'h8000_0040, 0,   0,  0);
    step("memb2",     1,  0, 0,  1, 1, 32'h8000_0040, C_MEMB, 32'h8000_0040, 1,   0,  0);
    step("memb3",     1,  0, 0,  1, 1, 32'h8000_0040, C_MEMB, 32'h8000_0040, 2,   0,  0);
    step("memb_br",   1,  0, 0,  0, 1, 32'h8000_0040, C_BR,   32'h8000_0040, 3,   0,  0);
    step("memb_post", 1,  0, 0,  0, 0, 32'h0,        C_NORM,  32'h0,        3,    0,  0);
    step("br_ifb",    1,  0, 1,  0, 1, 32'h8000_0100, C_BRIFB, 32'h8000_0100, 3,  0,  0);
    step("pend_busy", 1,  0, 1,  0, 0, 32'h0,        C_PBUSY, 32'h8000_0100, 4,   0,  0);
    step("pend_done", 1,  0, 0,  0, 0, 32'h0,        C_PDONE, 32'h8000_0100, 5,   0,  0);
    step("pend_exit", 1,  0, 0,  0, 0, 32'h0,        C_NORM,  32'h0,        5,    0,  0);
    step("br_ifb2",   1,  0, 1,  0, 1, 32'h8000_0200, C_BRIFB, 32'h8000_0200, 5,  0,  0);
    step("rst_pend",  0,  0, 1,  0, 0, 32'h0,        C_RST,   32'h8000_0200, 6,   0,  0);
    step("rst_exit",  1,  0, 0,  0, 0, 32'h0000_1234, C_NORM, 32'h0000_1234, 0,   0,  0);
    step("ifb",       1,  0, 1,  0, 0, 32'h0,        C_IFB,   32'h0,        0,    0,  0);
    step("ifb_lu",    1,  1, 1,  0, 0, 32'h0,        C_IFBLU, 32'h0,        1,    0,  0);
    step("ifb_post",  1,  0, 0,  0, 0, 32'h0,        C_NORM,  32'h0,        2,    0,  0);
    step("reset3",    0,  0, 0,  0, 0, 32'h0,        C_RST,   32'h0,        2,    2,  1);
    for (int i = 0; i < 20; i++)
      step("sat_lu",  1,  1, 0,  0, 0, 32'h0,        C_LU,    32'h0,        32'(i),
           (i > 15) ? 4'd15 : 4'(i), 1);
    step("sat_hold",  1,  0, 0,  0, 0, 32'h0,        C_NORM,  32'h0,        20,   15, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
